// File: rtl/cdb_arbiter.sv
// Common Data Bus writeback arbiter: one-entry holding buffer per functional unit,
// round-robin selection, one registered broadcast per cycle, flush discards pending results.
module cdb_arbiter #(
    parameter int unsigned NUM_UNITS = 4,
    parameter int unsigned TAG_W     = 4,
    parameter int unsigned DATA_W    = 32
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          flush,
    input  logic [NUM_UNITS-1:0]          req_valid,
    input  logic [NUM_UNITS*TAG_W-1:0]    req_tag,
    input  logic [NUM_UNITS*DATA_W-1:0]   req_data,
    output logic [NUM_UNITS-1:0]          req_ready,
    output logic                          cdb_valid,
    output logic [TAG_W-1:0]              cdb_tag,
    output logic [DATA_W-1:0]             cdb_data,
    output logic [2:0]                    cdb_src,
    output logic [NUM_UNITS-1:0]          pending
);

    logic [NUM_UNITS-1:0] buf_valid_q, buf_valid_d;
    logic [TAG_W-1:0]     buf_tag_q  [NUM_UNITS];
    logic [TAG_W-1:0]     buf_tag_d  [NUM_UNITS];
    logic [DATA_W-1:0]    buf_data_q [NUM_UNITS];
    logic [DATA_W-1:0]    buf_data_d [NUM_UNITS];
    logic [2:0]           rr_ptr_q, rr_ptr_d;

    logic                 cdb_valid_q, cdb_valid_d;
    logic [TAG_W-1:0]     cdb_tag_q, cdb_tag_d;
    logic [DATA_W-1:0]    cdb_data_q, cdb_data_d;
    logic [2:0]           cdb_src_q, cdb_src_d;

    logic [NUM_UNITS-1:0] grant;
    logic                 win_found;
    logic [2:0]           win_idx;
    logic [2:0]           win_next;
    logic [TAG_W-1:0]     win_tag;
    logic [DATA_W-1:0]    win_data;

    // Two passes: units at or above rr_ptr first, then wrap around from unit 0.
    always_comb begin : arbiter
        grant     = '0;
        win_found = 1'b0;
        win_idx   = '0;
        win_tag   = '0;
        win_data  = '0;
        for (int j = 0; j < int'(NUM_UNITS); j++) begin
            if (!win_found && buf_valid_q[j] && (j >= int'(rr_ptr_q))) begin
                win_found = 1'b1;
                grant[j]  = 1'b1;
                win_idx   = 3'(j);
                win_tag   = buf_tag_q[j];
                win_data  = buf_data_q[j];
            end
        end
        for (int j = 0; j < int'(NUM_UNITS); j++) begin
            if (!win_found && buf_valid_q[j]) begin
                win_found = 1'b1;
                grant[j]  = 1'b1;
                win_idx   = 3'(j);
                win_tag   = buf_tag_q[j];
                win_data  = buf_data_q[j];
            end
        end
        win_next = (int'(win_idx) == int'(NUM_UNITS) - 1) ? 3'd0 : win_idx + 3'd1;
    end

    // A granted entry empties this cycle, so its unit may refill it back-to-back.
    assign req_ready = {NUM_UNITS{~reset & ~flush}} & (~buf_valid_q | grant);

    always_comb begin : next_state
        buf_valid_d = buf_valid_q;
        buf_tag_d   = buf_tag_q;
        buf_data_d  = buf_data_q;
        rr_ptr_d    = rr_ptr_q;
        cdb_valid_d = 1'b0;
        cdb_tag_d   = cdb_tag_q;
        cdb_data_d  = cdb_data_q;
        cdb_src_d   = cdb_src_q;
        if (flush) begin
            buf_valid_d = '0;
        end else begin
            if (win_found) begin
                cdb_valid_d = 1'b1;
                cdb_tag_d   = win_tag;
                cdb_data_d  = win_data;
                cdb_src_d   = win_idx;
                buf_valid_d = buf_valid_q & ~grant;
                rr_ptr_d    = win_next;
            end
            for (int j = 0; j < int'(NUM_UNITS); j++) begin
                if (req_valid[j] && req_ready[j]) begin
                    buf_valid_d[j] = 1'b1;
                    buf_tag_d[j]   = req_tag[j*TAG_W +: TAG_W];
                    buf_data_d[j]  = req_data[j*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            buf_valid_q <= '0;
            rr_ptr_q    <= '0;
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_data_q  <= '0;
            cdb_src_q   <= '0;
        end else begin
            buf_valid_q <= buf_valid_d;
            rr_ptr_q    <= rr_ptr_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_data_q  <= cdb_data_d;
            cdb_src_q   <= cdb_src_d;
        end
    end

    // Payload is qualified by buf_valid, so it needs no reset.
    always_ff @(posedge clock) begin
        buf_tag_q  <= buf_tag_d;
        buf_data_q <= buf_data_d;
    end

    assign cdb_valid = cdb_valid_q;
    assign cdb_tag   = cdb_tag_q;
    assign cdb_data  = cdb_data_q;
    assign cdb_src   = cdb_src_q;
    assign pending   = buf_valid_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios with literal expectations, then randomized traffic,
// every cycle compared against a queue-free behavioural model of the buffers and pointer.
module tb_cdb_arbiter;

    localparam int N  = 4;
    localparam int TW = 4;
    localparam int DW = 32;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic            reset, flush;
    logic [N-1:0]    req_valid;
    logic [N*TW-1:0] req_tag;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            cdb_valid;
    logic [TW-1:0]   cdb_tag;
    logic [DW-1:0]   cdb_data;
    logic [2:0]      cdb_src;
    logic [N-1:0]    pending;

    cdb_arbiter #(.NUM_UNITS(N), .TAG_W(TW), .DATA_W(DW)) dut (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .req_valid (req_valid),
        .req_tag   (req_tag),
        .req_data  (req_data),
        .req_ready (req_ready),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_data  (cdb_data),
        .cdb_src   (cdb_src),
        .pending   (pending)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Model state
    logic [N-1:0]  mv = '0;
    logic [TW-1:0] mt [N];
    logic [DW-1:0] md [N];
    int            mptr = 0;
    logic          ev = 1'b0;
    logic [TW-1:0] et = '0;
    logic [DW-1:0] ed = '0;
    logic [2:0]    es = '0;
    logic [N-1:0]  stall = '0;

    function automatic int winner();
        for (int k = 0; k < N; k++) begin
            if (mv[(mptr + k) % N]) return (mptr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_ready();
        logic [N-1:0] r;
        int w = winner();
        for (int i = 0; i < N; i++) r[i] = !reset && !flush && (!mv[i] || i == w);
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        int w = winner();
        logic [N-1:0] rdy = exp_ready();
        if (reset) begin
            mv = '0; mptr = 0; ev = 1'b0; et = '0; ed = '0; es = '0;
        end else if (flush) begin
            mv = '0; ev = 1'b0;
        end else begin
            if (w >= 0) begin
                ev = 1'b1; et = mt[w]; ed = md[w]; es = 3'(w);
                mv[w] = 1'b0;
                mptr = (w + 1) % N;
            end else begin
                ev = 1'b0;
            end
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && rdy[i]) begin
                    mv[i] = 1'b1;
                    mt[i] = req_tag[i*TW +: TW];
                    md[i] = req_data[i*DW +: DW];
                end
            end
        end
    endtask

    // Inputs are already applied (after a negedge); compare, then clock one edge.
    task automatic step();
        #1;
        check("req_ready", 32'(req_ready), 32'(exp_ready()));
        check("pending", 32'(pending), 32'(mv));
        check("cdb_valid", 32'(cdb_valid), 32'(ev));
        check("cdb_tag", 32'(cdb_tag), 32'(et));
        check("cdb_data", cdb_data, ed);
        check("cdb_src", 32'(cdb_src), 32'(es));
        stall = req_valid & ~exp_ready() & {N{~reset & ~flush}};
        @(posedge clock);
        model_edge();
        @(negedge clock);
    endtask

    task automatic idle();
        req_valid = '0;
        flush     = 1'b0;
        reset     = 1'b0;
    endtask

    task automatic send(input int u, input logic [TW-1:0] t, input logic [DW-1:0] d);
        req_valid[u]           = 1'b1;
        req_tag[u*TW +: TW]    = t;
        req_data[u*DW +: DW]   = d;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; req_valid = '0; req_tag = '0; req_data = '0;
        @(posedge clock);
        model_edge();
        @(negedge clock);
        step();

        // Single result
        idle(); send(1, 4'd5, 32'h0000_00A0); step();
        idle(); step();
        check("single_valid", 32'(cdb_valid), 32'd1);
        check("single_tag", 32'(cdb_tag), 32'd5);
        check("single_data", cdb_data, 32'h0000_00A0);
        check("single_src", 32'(cdb_src), 32'd1);
        step();
        check("single_after", 32'(cdb_valid), 32'd0);

        // Contention from rr_ptr = 0
        idle(); reset = 1'b1; step();
        idle();
        for (int u = 0; u < N; u++) send(u, 4'(u + 1), 32'h100 + 32'(u));
        step();
        idle();
        for (int k = 0; k < N; k++) begin
            step();
            check("contend_tag", 32'(cdb_tag), 32'(k + 1));
            check("contend_src", 32'(cdb_src), 32'(k));
        end

        // Round-robin wrap
        idle(); send(2, 4'd2, 32'h22); step();
        idle(); send(0, 4'd1, 32'h10); send(3, 4'd3, 32'h30); step();
        check("wrap_src2", 32'(cdb_src), 32'd2);
        idle(); step();
        check("wrap_src3", 32'(cdb_src), 32'd3);
        idle(); send(1, 4'd4, 32'h41); send(3, 4'd5, 32'h53); step();
        check("wrap_src0", 32'(cdb_src), 32'd0);
        idle(); step();
        check("wrap_src1", 32'(cdb_src), 32'd1);
        step();
        check("wrap_src3b", 32'(cdb_src), 32'd3);

        // Back-to-back from one unit
        for (int k = 0; k < 4; k++) begin
            idle();
            if (k < 3) begin
                send(2, 4'(6 + k), 32'(k));
                #1 check("b2b_ready", 32'(req_ready[2]), 32'd1);
            end
            step();
            if (k >= 1) begin
                check("b2b_valid", 32'(cdb_valid), 32'd1);
                check("b2b_tag", 32'(cdb_tag), 32'(5 + k));
            end
        end

        // Backpressure on unit 0 with rr_ptr = 1
        idle(); reset = 1'b1; step();
        idle(); send(0, 4'd1, 32'h11); step();
        idle();
        send(0, 4'd9, 32'hDEAD_0009); send(1, 4'd10, 32'hA); send(2, 4'd11, 32'hB);
        send(3, 4'd12, 32'hC);
        step();
        idle(); send(0, 4'd14, 32'h0E);
        for (int k = 0; k < 3; k++) begin
            #1 check("bp_ready0", 32'(req_ready[0]), 32'd0);
            step();
            check("bp_src", 32'(cdb_src), 32'(k + 1));
        end
        #1 check("bp_ready0_grant", 32'(req_ready[0]), 32'd1);
        step();
        check("bp_src0", 32'(cdb_src), 32'd0);
        check("bp_tag9", 32'(cdb_tag), 32'd9);
        check("bp_data9", cdb_data, 32'hDEAD_0009);
        idle(); step();
        check("bp_tag14", 32'(cdb_tag), 32'd14);

        // Flush with three buffers full
        idle(); send(0, 4'd1, 32'h1); send(1, 4'd2, 32'h2); send(2, 4'd3, 32'h3); step();
        idle(); flush = 1'b1; step();
        check("flush_pending", 32'(pending), 32'd0);
        check("flush_valid", 32'(cdb_valid), 32'd0);
        idle();
        for (int k = 0; k < 3; k++) begin
            step();
            check("flush_quiet", 32'(cdb_valid), 32'd0);
        end

        // Reset with three buffers full
        idle(); send(1, 4'd7, 32'h7); send(2, 4'd8, 32'h8); send(3, 4'd9, 32'h9); step();
        idle(); reset = 1'b1; step();
        check("rst_valid", 32'(cdb_valid), 32'd0);
        check("rst_tag", 32'(cdb_tag), 32'd0);
        check("rst_data", cdb_data, 32'd0);
        check("rst_src", 32'(cdb_src), 32'd0);
        check("rst_pending", 32'(pending), 32'd0);
        idle(); send(3, 4'd3, 32'h3); send(0, 4'd4, 32'h4); step();
        idle(); step();
        check("rst_ptr0", 32'(cdb_src), 32'd0);

        // Randomized traffic; a stalled unit keeps its request stable
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 99) == 0);
            flush = ($urandom_range(0, 39) == 0);
            for (int i = 0; i < N; i++) begin
                if (!stall[i]) begin
                    req_valid[i]         = 1'($urandom_range(0, 1));
                    req_tag[i*TW +: TW]  = TW'($urandom);
                    req_data[i*DW +: DW] = $urandom;
                end
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
